// File: rtl/reaction_timer_pkg.sv
// rtl/reaction_timer_pkg.sv - shared types and constants for the reaction timer
package reaction_timer_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WAIT  = 3'd1,
        STIM  = 3'd2,
        DONE  = 3'd3,
        FALSE = 3'd4,
        TOUT  = 3'd5
    } state_t;

    localparam int          TIME_W    = 24;
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // Fibonacci taps 16,14,13,11 mapped onto bits 15,13,12,10
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {s[14:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/reaction_timer_core_ms_tick_gen.sv
// rtl/reaction_timer_core_ms_tick_gen.sv - millisecond prescaler with synchronous clear
module ms_tick_gen #(
    parameter int TICK_DIV = 50000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic ms_tick
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt;

    assign ms_tick = (cnt == LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (clear || ms_tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/reaction_timer_core.sv
// rtl/reaction_timer_core.sv - reaction trial FSM: random delay, stimulus, ms timing
// Optional macro REACTION_TIMER_FIXED_DELAY_EN: delay target is MIN_DELAY_MS exactly.
module reaction_timer_core
    import reaction_timer_pkg::*;
#(
    parameter int          TICK_DIV     = 50000,
    parameter int          MIN_DELAY_MS = 1000,
    parameter logic [15:0] RAND_MASK    = 16'h07FF,
    parameter int          MAX_TIME_MS  = 9999
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start_pulse,
    input  logic              react_pulse,
    output logic              stim_led,
    output logic [TIME_W-1:0] reaction_ms,
    output logic              update,
    output logic              false_start,
    output logic              timeout,
    output logic              busy
);

    localparam logic [TIME_W-1:0] MAX_CNT = TIME_W'(MAX_TIME_MS);

    state_t            state;
    logic [15:0]       lfsr;
    logic [TIME_W-1:0] ms_count;
    logic [16:0]       target;
    logic [16:0]       delay_target;
    logic              ms_tick;
    logic              go_wait, go_false, go_stim, go_done, go_tout, tick_clear;

`ifdef REACTION_TIMER_FIXED_DELAY_EN
    logic unused_rand;
    assign unused_rand  = ^(lfsr & RAND_MASK);
    assign delay_target = 17'(MIN_DELAY_MS);
`else
    assign delay_target = 17'(MIN_DELAY_MS) + {1'b0, lfsr & RAND_MASK};
`endif

    // WAIT leaves on the tick that brings the count up to the target, so WAIT lasts target ms
    always_comb begin
        go_wait  = start_pulse && (state inside {IDLE, DONE, FALSE, TOUT});
        go_false = (state == WAIT) && react_pulse;
        go_stim  = (state == WAIT) && !react_pulse && ms_tick
                   && ((ms_count + TIME_W'(1)) >= TIME_W'(target));
        go_done  = (state == STIM) && react_pulse;
        go_tout  = (state == STIM) && !react_pulse && ms_tick
                   && (ms_count >= (MAX_CNT - TIME_W'(1)));
        tick_clear = go_wait || go_false || go_stim || go_done || go_tout;
    end

    ms_tick_gen #(
        .TICK_DIV(TICK_DIV)
    ) u_tick (
        .clk    (clk),
        .reset  (reset),
        .clear  (tick_clear),
        .ms_tick(ms_tick)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lfsr <= LFSR_SEED;
        end else begin
            lfsr <= lfsr_next(lfsr);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            stim_led    <= 1'b0;
            reaction_ms <= '0;
            update      <= 1'b0;
            false_start <= 1'b0;
            timeout     <= 1'b0;
            busy        <= 1'b0;
            ms_count    <= '0;
            target      <= '0;
        end else begin
            update <= 1'b0;
            case (state)
                IDLE, DONE, FALSE, TOUT: begin
                    if (go_wait) begin
                        state       <= WAIT;
                        target      <= delay_target;
                        ms_count    <= '0;
                        busy        <= 1'b1;
                        false_start <= 1'b0;
                        timeout     <= 1'b0;
                    end
                end
                WAIT: begin
                    if (go_false) begin
                        state       <= FALSE;
                        false_start <= 1'b1;
                        busy        <= 1'b0;
                    end else if (go_stim) begin
                        state    <= STIM;
                        ms_count <= '0;
                        stim_led <= 1'b1;
                    end else if (ms_tick) begin
                        ms_count <= ms_count + TIME_W'(1);
                    end
                end
                STIM: begin
                    if (go_done) begin
                        state       <= DONE;
                        reaction_ms <= ms_count;
                        update      <= 1'b1;
                        stim_led    <= 1'b0;
                        busy        <= 1'b0;
                    end else if (go_tout) begin
                        // count pins at the limit; reaction_ms keeps the last good result
                        state    <= TOUT;
                        ms_count <= MAX_CNT;
                        timeout  <= 1'b1;
                        stim_led <= 1'b0;
                        busy     <= 1'b0;
                    end else if (ms_tick) begin
                        ms_count <= ms_count + TIME_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reaction_timer_core.sv
// tb/tb_reaction_timer_core.sv - randomized self-checking bench for reaction_timer_core
module tb_reaction_timer_core;

    localparam int TD    = 4;
    localparam int MIN_D = 3;
    localparam int MAX_T = 20;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start_pulse = 1'b0;
    logic        react_pulse = 1'b0;
    logic        stim_led;
    logic [23:0] reaction_ms;
    logic        update;
    logic        false_start;
    logic        timeout;
    logic        busy;

    int tests = 0;
    int fails = 0;
    int upd_seen = 0;

    reaction_timer_core #(
        .TICK_DIV(TD), .MIN_DELAY_MS(MIN_D), .RAND_MASK(16'h07FF), .MAX_TIME_MS(MAX_T)
    ) dut (
        .clk(clk), .reset(reset), .start_pulse(start_pulse), .react_pulse(react_pulse),
        .stim_led(stim_led), .reaction_ms(reaction_ms), .update(update),
        .false_start(false_start), .timeout(timeout), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(negedge clk) if (update === 1'b1) upd_seen++;

    // reference: STIM count seen at cycle c after entry is the number of whole ms elapsed
    function automatic int exp_reaction(input int c);
        return c / TD;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start_pulse = 1'b1;
        step();
        start_pulse = 1'b0;
    endtask

    task automatic react_after(input int c);
        repeat (c) step();
        react_pulse = 1'b1;
        step();
        react_pulse = 1'b0;
    endtask

    task automatic wait_stim(output int n, output bit ok);
        n = 0;
        ok = 1'b0;
        while (n < 9000) begin
            if (stim_led === 1'b1) begin
                ok = 1'b1;
                break;
            end
            step();
            n++;
        end
    endtask

    task automatic check_wait_len(input string name, input int n, input bit ok);
        tests++;
        if (!ok) begin fails++; $display("FAIL %s_stim_timeout: waited %0d cycles, required stim_led", name, n); end
`ifdef REACTION_TIMER_FIXED_DELAY_EN
        tests++;
        if (n != MIN_D * TD) begin fails++; $display("FAIL %s_wait_len: got %0d cycles, expected %0d", name, n, MIN_D * TD); end
`else
        tests++;
        if ((n % TD) != 0 || n / TD < MIN_D || n / TD > MIN_D + 2047) begin
            fails++; $display("FAIL %s_wait_len: got %0d cycles, expected multiple of %0d in [%0d,%0d] ms", name, n, TD, MIN_D, MIN_D + 2047);
        end
`endif
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) step();
        tests++;
        if ({stim_led, update, false_start, timeout, busy} !== 5'b0) begin
            fails++; $display("FAIL reset_flags: got %b expected 00000", {stim_led, update, false_start, timeout, busy});
        end
        tests++;
        if (reaction_ms !== 24'd0) begin fails++; $display("FAIL reset_reaction_ms: got %0d expected 0", reaction_ms); end
        reset = 1'b0;
        upd_seen = 0;
        react_pulse = 1'b1;
        step();
        react_pulse = 1'b0;
        step();
        tests++;
        if (busy !== 1'b0 || upd_seen != 0 || false_start !== 1'b0) begin
            fails++; $display("FAIL idle_react_ignored: busy=%b upd=%0d fs=%b expected 0 0 0", busy, upd_seen, false_start);
        end
    endtask

    task automatic test_basic();
        int n; bit ok;
        upd_seen = 0;
        pulse_start();
        tests++;
        if (busy !== 1'b1 || stim_led !== 1'b0) begin fails++; $display("FAIL basic_enter_wait: busy=%b stim=%b expected 1 0", busy, stim_led); end
        wait_stim(n, ok);
        check_wait_len("basic", n, ok);
        react_after(40);
        tests++;
        if (update !== 1'b1) begin fails++; $display("FAIL basic_update: got %b expected 1", update); end
        tests++;
        if (reaction_ms !== 24'(exp_reaction(40))) begin fails++; $display("FAIL basic_reaction_ms: got %0d expected %0d", reaction_ms, exp_reaction(40)); end
        tests++;
        if (stim_led !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL basic_done_outputs: stim=%b busy=%b expected 0 0", stim_led, busy); end
        step();
        tests++;
        if (update !== 1'b0) begin fails++; $display("FAIL basic_update_width: got %b expected 0", update); end
        react_pulse = 1'b1;
        step();
        react_pulse = 1'b0;
        step();
        tests++;
        if (upd_seen != 1 || reaction_ms !== 24'd10) begin
            fails++; $display("FAIL basic_done_react_ignored: updates=%0d ms=%0d expected 1 10", upd_seen, reaction_ms);
        end
    endtask

    task automatic test_false_start();
        int n; bit ok;
        upd_seen = 0;
        pulse_start();
        repeat (2 * TD) step();
        react_pulse = 1'b1;
        step();
        react_pulse = 1'b0;
        repeat (3) step();
        tests++;
        if (false_start !== 1'b1 || stim_led !== 1'b0 || busy !== 1'b0 || upd_seen != 0) begin
            fails++; $display("FAIL false_start_flag: fs=%b stim=%b busy=%b upd=%0d expected 1 0 0 0", false_start, stim_led, busy, upd_seen);
        end
        pulse_start();
        tests++;
        if (false_start !== 1'b0 || busy !== 1'b1) begin fails++; $display("FAIL false_start_clear: fs=%b busy=%b expected 0 1", false_start, busy); end
        wait_stim(n, ok);
        check_wait_len("false_retry", n, ok);
        react_after(40);
        tests++;
        if (reaction_ms !== 24'd10) begin fails++; $display("FAIL false_retry_ms: got %0d expected 10", reaction_ms); end
    endtask

    task automatic test_timeout();
        int n; bit ok;
        pulse_start();
        wait_stim(n, ok);
        check_wait_len("timeout", n, ok);
        upd_seen = 0;
        repeat (MAX_T * TD - 1) step();
        tests++;
        if (timeout !== 1'b0 || stim_led !== 1'b1) begin fails++; $display("FAIL timeout_early: tout=%b stim=%b expected 0 1", timeout, stim_led); end
        step();
        tests++;
        if (timeout !== 1'b1 || stim_led !== 1'b0 || busy !== 1'b0) begin
            fails++; $display("FAIL timeout_flag: tout=%b stim=%b busy=%b expected 1 0 0", timeout, stim_led, busy);
        end
        repeat (2) step();
        tests++;
        if (reaction_ms !== 24'd10 || upd_seen != 0) begin
            fails++; $display("FAIL timeout_no_update: ms=%0d upd=%0d expected 10 0", reaction_ms, upd_seen);
        end
        pulse_start();
        tests++;
        if (timeout !== 1'b0) begin fails++; $display("FAIL timeout_clear: got %b expected 0", timeout); end
        wait_stim(n, ok);
        react_after(8);
    endtask

    task automatic test_tick_collision();
        int n; bit ok;
        pulse_start();
        wait_stim(n, ok);
        check_wait_len("collision", n, ok);
        react_after(5 * TD + TD - 1);
        tests++;
        if (reaction_ms !== 24'd5 || update !== 1'b1) begin
            fails++; $display("FAIL tick_collision: ms=%0d upd=%b expected 5 1", reaction_ms, update);
        end
    endtask

    task automatic test_reset_mid_stim();
        int n; bit ok;
        pulse_start();
        wait_stim(n, ok);
        check_wait_len("reset_mid", n, ok);
        repeat (10) step();
        upd_seen = 0;
        #2 reset = 1'b1;
        #1;
        tests++;
        if ({stim_led, update, false_start, timeout, busy} !== 5'b0 || reaction_ms !== 24'd0) begin
            fails++; $display("FAIL reset_mid_stim: flags=%b ms=%0d expected 00000 0", {stim_led, update, false_start, timeout, busy}, reaction_ms);
        end
        step();
        reset = 1'b0;
        react_pulse = 1'b1;
        step();
        react_pulse = 1'b0;
        step();
        tests++;
        if (busy !== 1'b0 || upd_seen != 0 || false_start !== 1'b0) begin
            fails++; $display("FAIL reset_mid_idle: busy=%b upd=%0d fs=%b expected 0 0 0", busy, upd_seen, false_start);
        end
    endtask

    task automatic test_random_delay();
        int n, c;
        bit ok;
        int lens[8];
        for (int i = 0; i < 8; i++) begin
            repeat ($urandom_range(0, 7)) step();
            pulse_start();
            wait_stim(n, ok);
            lens[i] = n;
            check_wait_len("random", n, ok);
            c = $urandom_range(0, MAX_T * TD - 8);
            for (int j = 0; j < c; j++) begin
                start_pulse = (j == c / 2) && (c > 1);
                step();
            end
            start_pulse = 1'b0;
            tests++;
            if (stim_led !== 1'b1 || busy !== 1'b1) begin fails++; $display("FAIL random_start_ignored: stim=%b busy=%b expected 1 1", stim_led, busy); end
            react_pulse = 1'b1;
            step();
            react_pulse = 1'b0;
            tests++;
            if (update !== 1'b1 || reaction_ms !== 24'(exp_reaction(c))) begin
                fails++; $display("FAIL random_reaction: trial %0d upd=%b ms=%0d expected 1 %0d", i, update, reaction_ms, exp_reaction(c));
            end
        end
`ifndef REACTION_TIMER_FIXED_DELAY_EN
        begin
            bit all_eq = 1'b1;
            for (int i = 1; i < 8; i++) if (lens[i] != lens[0]) all_eq = 1'b0;
            tests++;
            if (all_eq) begin fails++; $display("FAIL random_spread: all 8 waits %0d cycles, expected variation", lens[0]); end
        end
`endif
    endtask

    initial begin
        test_reset();
        test_basic();
        test_false_start();
        test_timeout();
        test_tick_collision();
        test_reset_mid_stim();
        test_random_delay();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/reaction_timer_core.md
Name: reaction_timer_core

Overview:
- Upstream stage of the best-time register.
- Runs one reaction trial per start press:
  - waits a pseudo-random delay;
  - lights the stimulus LED;
  - counts milliseconds until the react press.
- Produces a 24-bit reaction time in ms and a 1-cycle update strobe. These drive high_score_register's new_time/update directly and the display path.
- Also flags false starts (react before stimulus) and timeouts. Neither flag produces an update.

Parameters:
- TICK_DIV, 50000, clk cycles per 1 ms tick (50 MHz clock).
- MIN_DELAY_MS, 1000, fixed part of the pre-stimulus delay in ms.
- RAND_MASK, 16'h07FF, mask applied to the LFSR value. Random delay part is 0..2047 ms.
- MAX_TIME_MS, 9999, reaction count at which the trial times out.

Ports:
- clk  input  1  system clock, 50 MHz
- reset  input  1  asynchronous, active-high reset
- start_pulse  input  1  1-cycle pulse, debounced/synchronized start button
- react_pulse  input  1  1-cycle pulse, debounced/synchronized react button
- stim_led  output  1  stimulus LED; high only in STIM
- reaction_ms  output  24  last reaction time in ms; held until next trial result
- update  output  1  1-cycle strobe; reaction_ms valid and new
- false_start  output  1  sticky; high in FALSE state
- timeout  output  1  sticky; high in TOUT state
- busy  output  1  high in WAIT or STIM

Behaviour:
- Clocking and reset:
  - Single clock domain.
  - Reset is asynchronous and active-high.
- Reset values:
  - state=IDLE
  - stim_led=0, update=0, false_start=0, timeout=0, busy=0
  - reaction_ms=0
  - ms counter=0, tick prescaler=0
  - LFSR=16'hACE1
- LFSR:
  - 16-bit Fibonacci, taps 16,14,13,11.
  - Free-running every cycle, including IDLE. Never reaches zero.
- Tick prescaler:
  - Counts 0..TICK_DIV-1; ms_tick=1 on the cycle it equals TICK_DIV-1, then wraps.
  - Cleared to 0 on every state entry, so the first tick falls TICK_DIV cycles after entry.
- States and transitions:
  - IDLE:
    - start_pulse -> WAIT.
    - On that edge: delay target = MIN_DELAY_MS + (lfsr & RAND_MASK); ms count=0.
  - WAIT:
    - ms_tick increments ms count.
    - react_pulse -> FALSE (takes priority over a same-cycle delay expiry).
    - ms count == target on a tick -> STIM; ms count=0.
  - STIM:
    - stim_led=1; ms_tick increments ms count.
    - react_pulse -> DONE; reaction_ms <= current ms count. A tick in the same cycle is not added.
    - ms count reaches MAX_TIME_MS -> TOUT; reaction_ms unchanged.
  - DONE:
    - update=1 for exactly the entry cycle, then 0.
    - start_pulse -> WAIT, new trial.
  - FALSE and TOUT:
    - Flag high while in state.
    - start_pulse -> WAIT and clears the flag.
- Latency: react_pulse sampled at cycle N in STIM -> reaction_ms and update valid at N+1.
- Ignored inputs:
  - start_pulse in WAIT or STIM is ignored.
  - react_pulse in IDLE, DONE, FALSE or TOUT is ignored.
- Width rules:
  - ms counter is 24-bit and saturates at MAX_TIME_MS.
  - Delay target is 17-bit, compared zero-extended.
- Reset mid-trial: immediate return to IDLE; no update strobe.

Optional Feature:
- Macro: REACTION_TIMER_FIXED_DELAY_EN.
- Defined: delay target = MIN_DELAY_MS exactly; the LFSR is not used for the delay. Gives deterministic benches and demos.
- Undefined: random delay as above.

Decomposition:
- Shared package reaction_timer_pkg holds:
  - state enum (IDLE, WAIT, STIM, DONE, FALSE, TOUT);
  - TIME_W=24;
  - LFSR seed 16'hACE1 and tap constants.
- Sub-module ms_tick_gen (prescaler with clear input, parameter TICK_DIV, output ms_tick).
- The LFSR stays inline.

Test Plan (all with TICK_DIV=4, MIN_DELAY_MS=3, MAX_TIME_MS=20):
- Basic trial, FIXED_DELAY_EN: start, react 10 ticks (40 cycles) after stim_led rises -> reaction_ms=10, update high exactly 1 cycle, cycle after react.
- React 2 ticks into WAIT -> false_start=1, stim_led stays 0, no update; next start clears false_start.
- No react during STIM -> timeout=1 after 20 ticks, reaction_ms keeps previous value 10, no update.
- React on the same cycle as ms_tick with count=5 -> reaction_ms=5, not 6.
- Reset asserted mid-STIM -> all outputs at reset values on the same edge, state IDLE, no update.
- Random delay: without the macro, 8 trials -> each WAIT length in [3, 3+2047] ms, not all equal; start pulses during STIM ignored.
